// File: rtl/mvu_job_scheduler.sv
// mvu_job_scheduler: APB-programmed job dispatcher for an array of NMVU
// matrix-vector units. Software pushes 32-bit job descriptors into a FIFO and
// the scheduler issues each one to a fixed MVU or to the next idle MVU in
// round-robin order, using a one-cycle start pulse.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   apb_*                   APB slave (zero wait states, combinational read data)
//   mvu_start[NMVU]         one-cycle dispatch pulse per MVU
//   mvu_payload[28]         job payload, valid while any mvu_start bit is high
//   mvu_done[NMVU]          one-cycle completion pulse per MVU
//   irq                     level interrupt, |(done & irq_en), registered
module mvu_job_scheduler #(
  parameter int unsigned NMVU           = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned APB_ADDR_WIDTH = 15,
  parameter int unsigned APB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata,
  output logic                      apb_pready,
  output logic                      apb_pslverr,
  output logic [NMVU-1:0]           mvu_start,
  output logic [27:0]               mvu_payload,
  input  logic [NMVU-1:0]           mvu_done,
  output logic                      irq
);
  localparam int unsigned IW = (NMVU > 1) ? $clog2(NMVU) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_JOB    = APB_ADDR_WIDTH'(32'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS = APB_ADDR_WIDTH'(32'h04);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_DONE   = APB_ADDR_WIDTH'(32'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IRQEN  = APB_ADDR_WIDTH'(32'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL   = APB_ADDR_WIDTH'(32'h10);

  typedef struct packed {
    logic        any;
    logic [2:0]  target;
    logic [27:0] payload;
  } job_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PICK = 2'd1, S_ISSUE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, rr_q, any_idx, cand, head_tgt;
  logic            any_found;
  logic [NMVU-1:0] busy_q, done_q, irq_en_q, done_hit, done_clr, start_d;
  logic [27:0]     payload_d;
  logic            enable_q, overflow_q;

  job_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  job_t            head;

  logic access, wr_en, full, empty, pop, push_req, push_ok, flush;
  logic sel_job, sel_status, sel_done, sel_irqen, sel_ctrl, sel_valid;
  logic [31:0] status_w;

  // Register decode and APB handshake
  assign access     = apb_psel & apb_penable;
  assign wr_en      = access & apb_pwrite;
  assign sel_job    = (apb_paddr == ADDR_JOB);
  assign sel_status = (apb_paddr == ADDR_STATUS);
  assign sel_done   = (apb_paddr == ADDR_DONE);
  assign sel_irqen  = (apb_paddr == ADDR_IRQEN);
  assign sel_ctrl   = (apb_paddr == ADDR_CTRL);
  assign sel_valid  = sel_job | sel_status | sel_done | sel_irqen | sel_ctrl;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == S_ISSUE) && !empty;
  assign push_req = wr_en & sel_job;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok  = push_req & (!full | pop);
  assign flush    = wr_en & sel_ctrl & apb_pwdata[1];

  assign apb_pready  = 1'b1;
  assign apb_pslverr = access & (!sel_valid | (apb_pwrite & sel_status) | (push_req & !push_ok));

  // Status word assembly
  always_comb begin
    status_w        = '0;
    status_w[7:0]   = 8'(busy_q);
    status_w[12:8]  = 5'(count_q);
    status_w[16]    = full;
    status_w[17]    = empty;
    status_w[18]    = overflow_q;
    status_w[21:20] = state_q;
  end

  // Read mux
  always_comb begin
    apb_prdata = '0;
    if (apb_psel && !apb_pwrite) begin
      if (sel_status)     apb_prdata = APB_DATA_WIDTH'(status_w);
      else if (sel_done)  apb_prdata = APB_DATA_WIDTH'(done_q);
      else if (sel_irqen) apb_prdata = APB_DATA_WIDTH'(irq_en_q);
      else if (sel_ctrl)  apb_prdata = APB_DATA_WIDTH'(enable_q);
    end
  end

  assign head     = mem[rd_ptr_q];
  assign head_tgt = head.target[IW-1:0];

  // Round-robin idle search starting at rr_ptr+1; descending loop lets the nearest win
  always_comb begin
    any_found = 1'b0;
    any_idx   = '0;
    cand      = '0;
    for (int k = int'(NMVU); k >= 1; k--) begin
      cand = rr_q + IW'(k);
      if (!busy_q[cand]) begin
        any_found = 1'b1;
        any_idx   = cand;
      end
    end
  end

  // Dispatch FSM next-state and start/payload decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = '0;
    payload_d = '0;
    case (state_q)
      S_IDLE: if (enable_q && !empty) state_d = S_PICK;
      S_PICK: begin
        if (!enable_q || flush || empty) begin
          state_d = S_IDLE;
        end else if (head.any) begin
          if (any_found) begin
            state_d = S_ISSUE;
            idx_d   = any_idx;
          end
        end else if (!busy_q[head_tgt]) begin
          state_d = S_ISSUE;
          idx_d   = head_tgt;
        end
        if (state_d == S_ISSUE) begin
          start_d[idx_d] = 1'b1;
          payload_d      = head.payload;
        end
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completions only count for MVUs we believe are busy
  assign done_hit = mvu_done & busy_q;
  assign done_clr = (wr_en && sel_done) ? apb_pwdata[NMVU-1:0] : '0;

  // State, tracking and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rr_q        <= '0;
      mvu_start   <= '0;
      mvu_payload <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      irq_en_q    <= '0;
      irq         <= 1'b0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mvu_start   <= start_d;
      mvu_payload <= payload_d;
      // mvu_start is high exactly during ISSUE, so it doubles as the busy-set mask
      busy_q      <= (busy_q & ~done_hit) | mvu_start;
      done_q      <= (done_q & ~done_clr) | done_hit;
      irq         <= |(done_q & irq_en_q);
      if (state_q == S_ISSUE) rr_q <= idx_q;
      if (wr_en && sel_irqen) begin
        irq_en_q <= apb_pwdata[NMVU-1:0];
        if (apb_pwdata[31]) overflow_q <= 1'b0;
      end
      if (push_req && !push_ok) overflow_q <= 1'b1;
      if (wr_en && sel_ctrl) enable_q <= apb_pwdata[0];
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push_ok) - CW'(pop);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= job_t'(apb_pwdata[31:0]);
  end
endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Directed bench for mvu_job_scheduler: expected dispatches are queued when a
// job is pushed and checked when mvu_start fires.
module tb_mvu_job_scheduler;
  localparam int unsigned NMVU = 8;
  localparam logic [31:0] ANY  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [NMVU-1:0] mvu_start, mvu_done;
  logic [27:0] mvu_payload;
  logic        irq;

  mvu_job_scheduler #(.NMVU(8), .FIFO_DEPTH(8), .APB_ADDR_WIDTH(15), .APB_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr),
    .mvu_start(mvu_start), .mvu_payload(mvu_payload), .mvu_done(mvu_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstart = 0;
  int last_commit = 0;
  int slog[$];

  typedef struct packed {
    logic [7:0]  start;
    logic [27:0] payload;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard check on every dispatch pulse
  always @(negedge clk) begin
    if (mvu_start !== '0) begin
      slog.push_back(cyc);
      nstart++;
      if (sbq.size() != 0) mon_e = sbq.pop_front();
      else                 mon_e = '1;
      total += 2;
      assert (mvu_start === mon_e.start) else begin
        bad++; $error("FAIL start: observed=0x%02h expected=0x%02h", mvu_start, mon_e.start);
      end
      assert (mvu_payload === mon_e.payload) else begin
        bad++; $error("FAIL payload: observed=0x%07h expected=0x%07h", mvu_payload, mon_e.payload);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [14:0] a, input logic [31:0] d, input logic [7:0] dn, output logic err);
    @(negedge clk);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1; mvu_done = dn;
    #1 err = pslverr;
    @(posedge clk);
    #1 last_commit = cyc;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mvu_done = '0;
  endtask

  task automatic apb_rd(input logic [14:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [14:0] a, input logic [31:0] d, input logic exp_err);
    logic e;
    apb_wr(a, d, 8'h00, e);
    chk(tag, 32'(e), 32'(exp_err));
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_rd(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic push(input logic [31:0] w, input int idx);
    exp_t e;
    e.start   = 8'b1 << idx;
    e.payload = w[27:0];
    sbq.push_back(e);
    wr("push_err", 15'h00, w, 1'b0);
  endtask

  task automatic pulse_done(input logic [7:0] m);
    @(negedge clk) mvu_done = m;
    @(negedge clk) mvu_done = '0;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k;
    k = 0;
    while (nstart < n && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(nstart >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int t_push;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; mvu_done = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", 32'(mvu_start), 32'h0);
    chk("rst_payload", 32'(mvu_payload), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("pready", 32'(pready), 32'h1);
    rst_n = 1'b1;
    rd("status_reset", 15'h04, 32'h0002_0000);

    // Basic ANY dispatch, latency, done and interrupt
    wr("ctrl_en", 15'h10, 32'h1, 1'b0);
    push(32'h8000_0ABC, 1);
    t_push = last_commit;
    wait_starts(1, "wait_first");
    chk("latency", 32'(slog[0]), 32'(t_push + 2));
    rd("status_busy1", 15'h04, 32'h0002_0002);
    wr("irqen_w", 15'h0C, 32'h2, 1'b0);
    pulse_done(8'h02);
    #1 chk("irq_lag", 32'(irq), 32'h0);
    @(negedge clk); #1 chk("irq_set", 32'(irq), 32'h1);
    rd("status_idle", 15'h04, 32'h0002_0000);
    rd("done_rd", 15'h08, 32'h2);
    wr("done_w1c", 15'h08, 32'h2, 1'b0);
    chk("irq_hold", 32'(irq), 32'h1);
    @(posedge clk); #1 chk("irq_clr", 32'(irq), 32'h0);
    rd("done_cleared", 15'h08, 32'h0);

    // Round-robin across all MVUs, ninth job waits for a completion
    do_reset();
    wr("ctrl_en2", 15'h10, 32'h1, 1'b0);
    for (int i = 0; i < 9; i++) push(ANY | 32'(12'h100 + i), (i < 7) ? i + 1 : ((i == 7) ? 0 : 2));
    wait_starts(9, "wait_rr8");
    for (int j = 2; j <= 8; j++) chk("rr_spacing", 32'(slog[j] - slog[j-1]), 32'd3);
    repeat (3) @(negedge clk);
    rd("status_pick_full_busy", 15'h04, 32'h0010_01FF);
    chk("ninth_held", 32'(nstart), 32'd9);
    pulse_done(8'h44);
    wait_starts(10, "wait_ninth");
    rd("status_after9", 15'h04, 32'h0002_00BF);
    chk("irq_masked", 32'(irq), 32'h0);

    // Head-of-line blocking on a busy target
    push(32'h3000_0123, 3);
    push(ANY | 32'h456, 4);
    repeat (6) @(negedge clk);
    #1 chk("hol_blocked", 32'(nstart), 32'd10);
    rd("status_hol", 15'h04, 32'h0010_02BF);
    pulse_done(8'h18);
    wait_starts(12, "wait_hol");
    rd("done_mask", 15'h08, 32'h0000_005C);
    apb_wr(15'h08, 32'hFF, 8'h01, e);
    chk("done_w1c_err", 32'(e), 32'h0);
    rd("done_set_wins", 15'h08, 32'h0000_0001);
    pulse_done(8'h40);
    rd("done_idle_ignored", 15'h08, 32'h0000_0001);

    // FIFO overflow, overflow clear and flush
    wr("ctrl_dis", 15'h10, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) wr("fill", 15'h00, 32'h0000_0500 + 32'(i), 1'b0);
    wr("overflow_err", 15'h00, 32'h0000_0600, 1'b1);
    rd("status_full", 15'h04, 32'h0005_08BE);
    wr("ovf_clear", 15'h0C, 32'h8000_0000, 1'b0);
    rd("status_ovf_clr", 15'h04, 32'h0001_08BE);
    rd("irqen_bit31", 15'h0C, 32'h0);
    wr("flush", 15'h10, 32'h2, 1'b0);
    rd("status_flushed", 15'h04, 32'h0002_00BE);
    rd("ctrl_rd", 15'h10, 32'h0);
    chk("flush_no_start", 32'(nstart), 32'd12);

    // Bad accesses, then asynchronous reset while jobs are in flight
    apb_rd(15'h14, d, e);
    chk("bad_rd_err", 32'(e), 32'h1);
    chk("bad_rd_data", d, 32'h0);
    wr("status_wr_err", 15'h04, 32'hFFFF_FFFF, 1'b1);
    rd("status_unchanged", 15'h04, 32'h0002_00BE);
    wr("irqen0", 15'h0C, 32'h1, 1'b0);
    wr("ctrl_en3", 15'h10, 32'h1, 1'b0);
    push(ANY | 32'h777, 6);
    push(ANY | 32'h888, 0);
    wait_starts(14, "wait_fill_all");
    wr("push_stuck", 15'h00, ANY | 32'h999, 1'b0);
    repeat (4) @(negedge clk);
    rd("status_all_busy", 15'h04, 32'h0010_01FF);
    chk("irq_before_rst", 32'(irq), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(mvu_start), 32'h0);
    chk("arst_payload", 32'(mvu_payload), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    rd("status_post_rst", 15'h04, 32'h0002_0000);
    pulse_done(8'hFF);
    rd("done_forgotten", 15'h08, 32'h0);
    rd("status_final", 15'h04, 32'h0002_0000);
    repeat (4) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    chk("start_count", 32'(nstart), 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mvu_job_scheduler.md
Name: mvu_job_scheduler

Overview:
- APB-programmed job dispatcher sitting between the host APB slave port and an array of NMVU matrix-vector units.
- Software pushes 32-bit job descriptors into an internal FIFO.
- Scheduler dispatches each job to a specific MVU, or to any idle MVU chosen round-robin, with a one-cycle start pulse.
- Tracks per-MVU busy/done state and raises a maskable interrupt.

Parameters:
NMVU, 8, number of MVUs served; power of two, 2..8; IW = $clog2(NMVU)
FIFO_DEPTH, 8, job FIFO entries; power of two, 2..16
APB_ADDR_WIDTH, 15, APB address width
APB_DATA_WIDTH, 32, APB data width; fixed at 32

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active low
apb_paddr  in  APB_ADDR_WIDTH  byte address
apb_psel  in  1  APB select
apb_penable  in  1  APB access phase
apb_pwrite  in  1  1 = write
apb_pwdata  in  32  write data
apb_prdata  out  32  read data
apb_pready  out  1  tied 1 (zero wait states)
apb_pslverr  out  1  access error
mvu_start  out  NMVU  one-cycle dispatch pulse per MVU
mvu_payload  out  28  job payload, valid only while a mvu_start bit is high
mvu_done  in  NMVU  one-cycle completion pulse per MVU
irq  out  1  level interrupt

Behaviour:
- Reset values: mvu_start=0, mvu_payload=0, irq=0, apb_prdata=0, apb_pslverr=0. FIFO empty; busy, done, overflow, irq_en, enable, rr_ptr all 0.
- APB write commits on psel & penable & pwrite. Read data is combinational from registers while psel & !pwrite, otherwise 0.
- apb_pslverr is asserted only in the access phase.
- Register map (offset, name, access):
  - 0x00 JOB_PUSH, W. Job word: [31] ANY, [30:28] TARGET (low IW bits used), [27:0] PAYLOAD. If FIFO is full: word dropped, overflow sticky set, pslverr=1.
  - 0x04 STATUS, R. [7:0] busy mask (zero-extended), [12:8] fifo count, [16] full, [17] empty, [18] overflow sticky, [21:20] FSM state.
  - 0x08 DONE, R/W1C. [NMVU-1:0] sticky done mask. Writing 1 clears a bit; same-cycle mvu_done set wins over clear.
  - 0x0C IRQ_EN, RW. [NMVU-1:0] irq enable mask. Bit [31] set clears overflow sticky; bit [31] reads 0.
  - 0x10 CTRL, RW. [0] dispatch enable. [1] flush: self-clearing, empties FIFO, reads 0.
  - Any other offset, or a write to STATUS: pslverr=1, no side effect, read data 0.
- irq = |(done & irq_en), registered, one cycle after done/irq_en changes.
- Dispatch FSM:
  - IDLE: if enable && !empty -> PICK.
  - PICK: examine FIFO head.
    - ANY=1: search idle MVUs starting at (rr_ptr+1) mod NMVU, wrapping. If one is found, latch index -> ISSUE; else stay in PICK.
    - ANY=0: if busy[TARGET]==0 -> ISSUE; else stay in PICK (head-of-line blocking, later jobs do not bypass).
    - enable dropped or FIFO flushed while in PICK -> IDLE.
  - ISSUE: mvu_start[idx]=1 and mvu_payload=PAYLOAD for exactly one cycle. Same cycle: busy[idx] set, FIFO popped, rr_ptr=idx on every issue (targeted or ANY). Next state IDLE.
- Latency:
  - JOB_PUSH committed at edge t into an empty FIFO with enable=1 and target idle -> mvu_start high in the cycle following edge t+2.
  - Maximum issue rate is one job per 3 cycles.
- mvu_done[i] with busy[i]=1: clears busy[i] and sets done[i] on the same edge. mvu_done[i] with busy[i]=0 is ignored.
- A done on MVU i makes it selectable in the PICK evaluated on the following cycle.
- Push and pop in the same cycle:
  - When full: the push is accepted (count unchanged) and no error is raised.
  - When empty: no pop can occur.
- Flush in the same cycle as ISSUE: the issuing job completes. FIFO is empty afterwards; the concurrent push is also discarded.
- Clearing enable does not abort an ISSUE in progress.
- rst_n asserted at any time: all state returns to reset values immediately (asynchronous). In-flight MVU jobs are forgotten and their later mvu_done pulses are ignored.

Test Plan:
- Reset, then write CTRL=1 and push 0x8000_0ABC -> mvu_start=0x02 (rr_ptr 0 -> MVU1) for one cycle with payload 0x0000ABC. STATUS busy=0x02. Pulse mvu_done[1] -> busy=0, DONE=0x02; with IRQ_EN=0x02, irq=1 one cycle later; W1C DONE=0x02 -> irq=0.
- Enable with all MVUs idle, push 9 ANY jobs -> starts on MVU1,2,...,7,0, each 3 cycles apart. The 9th job waits in PICK until any mvu_done, then issues to that MVU (search from rr_ptr+1=1).
- Push targeted job TARGET=3 while busy[3]=1, followed by an ANY job -> neither issues until mvu_done[3]. Then job 1 goes to MVU3, and the ANY job goes to MVU4 (from rr_ptr+1=4).
- CTRL=0, push 9 jobs -> 9th push pslverr=1, STATUS count=8, full=1, overflow=1. IRQ_EN write with bit31 set clears overflow. CTRL=0x2 -> count=0, empty=1, no mvu_start.
- Read 0x14 and write 0x04 -> pslverr=1, prdata=0, STATUS unchanged. Assert rst_n=0 mid-PICK with busy=0xFF -> outputs 0 asynchronously, STATUS reads 0x0002_0000 after release.
